// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with selectable bit order,
// read handshake and sticky overrun / framing-error flags.
module serial_word_receiver #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             sin,
    input  logic             sstart,
    input  logic             msb_first,
    input  logic             rd_ack,
    output logic [WIDTH-1:0] D,
    output logic             valid,
    output logic             busy,
    output logic             overrun,
    output logic             ferr
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sr;
    logic             order;

    logic [WIDTH-1:0] sr_next;
    logic [WIDTH-1:0] first_word;
    logic             last;
    logic             done;

    always_comb begin
        sr_next    = sr;
        first_word = '0;
        if (order) begin
            sr_next = {sr[WIDTH-2:0], sin};
        end else begin
            sr_next = {sin, sr[WIDTH-1:1]};
        end
        if (msb_first) begin
            first_word = {{(WIDTH-1){1'b0}}, sin};
        end else begin
            first_word = {sin, {(WIDTH-1){1'b0}}};
        end
    end

    assign last = (cnt == CW'(WIDTH - 1));
    // An sstart on the final-bit edge aborts rather than completes.
    assign done = (state == SHIFT) && !sstart && last;

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            state   <= IDLE;
            cnt     <= '0;
            sr      <= '0;
            order   <= 1'b0;
            D       <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            overrun <= 1'b0;
            ferr    <= 1'b0;
        end else begin
            if (sstart) begin
                if (state == SHIFT) begin
                    ferr <= 1'b1;
                end
                state <= SHIFT;
                busy  <= 1'b1;
                order <= msb_first;
                sr    <= first_word;
                cnt   <= CW'(1);
            end else if (state == SHIFT) begin
                sr <= sr_next;
                if (last) begin
                    D     <= sr_next;
                    state <= IDLE;
                    busy  <= 1'b0;
                    cnt   <= '0;
                end else begin
                    cnt <= cnt + CW'(1);
                end
            end

            if (done) begin
                valid <= 1'b1;
                if (valid && !rd_ack) begin
                    overrun <= 1'b1;
                end
            end else if (rd_ack) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: scoreboard of completed
// words checked by a monitor, plus inline checks of control outputs.
module tb_serial_word_receiver;

    logic       clk = 1'b0;
    logic       clear;
    logic       sin;
    logic       sstart;
    logic       msb_first;
    logic       rd_ack;
    logic [3:0] d;
    logic       valid;
    logic       busy;
    logic       overrun;
    logic       ferr;

    int checks   = 0;
    int failures = 0;

    typedef struct packed {
        logic [3:0] d;
        logic       ov;
        logic       fe;
    } exp_t;

    exp_t sb[$];

    serial_word_receiver #(.WIDTH(4)) dut (
        .clk      (clk),
        .clear    (clear),
        .sin      (sin),
        .sstart   (sstart),
        .msb_first(msb_first),
        .rd_ack   (rd_ack),
        .D        (d),
        .valid    (valid),
        .busy     (busy),
        .overrun  (overrun),
        .ferr     (ferr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a new word is presented when valid rises or D changes.
    logic       prev_valid = 1'b0;
    logic [3:0] prev_d     = 4'h0;
    always @(negedge clk) begin
        if (valid === 1'b1 && (!prev_valid || d !== prev_d)) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_word: got D=%b none expected", d);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("word_D", 32'(d), 32'(e.d));
                chk("word_overrun", 32'(overrun), 32'(e.ov));
                chk("word_ferr", 32'(ferr), 32'(e.fe));
            end
        end
        prev_valid = valid;
        prev_d     = d;
    end

    task automatic drive(input logic st, input logic s, input logic m,
                         input logic ack);
        @(negedge clk);
        sstart    = st;
        sin       = s;
        msb_first = m;
        rd_ack    = ack;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    // bits[3] is the first bit on the line
    task automatic frame(input logic m, input logic [3:0] bits,
                         input logic ack_last);
        for (int i = 0; i < 4; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1 chk("busy_mid_frame", 32'(busy), 32'd1);
            end
            drive(i == 0, bits[3-i], m, ack_last && (i == 3));
        end
    endtask

    initial begin
        clear     = 1'b1;
        sin       = 1'b0;
        sstart    = 1'b0;
        msb_first = 1'b0;
        rd_ack    = 1'b0;
        #1;
        chk("reset_D", 32'(d), 32'd0);
        chk("reset_valid", 32'(valid), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_overrun", 32'(overrun), 32'd0);
        chk("reset_ferr", 32'(ferr), 32'd0);
        @(negedge clk);
        @(negedge clk);
        clear = 1'b0;

        // rd_ack with nothing pending
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("ack_idle_valid", 32'(valid), 32'd0);

        // MSB-first 1011
        sb.push_back('{d: 4'b1011, ov: 1'b0, fe: 1'b0});
        frame(1'b1, 4'b1011, 1'b0);
        idle();
        chk("msb_done_busy", 32'(busy), 32'd0);
        chk("msb_done_valid", 32'(valid), 32'd1);
        idle();

        // LSB-first 1,1,0,1 assembles to 1011 (acked first)
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        sb.push_back('{d: 4'b1011, ov: 1'b0, fe: 1'b0});
        frame(1'b0, 4'b1101, 1'b0);
        idle();
        chk("lsb_valid", 32'(valid), 32'd1);
        chk("lsb_D", 32'(d), 32'b1011);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();
        chk("lsb_ack_valid", 32'(valid), 32'd0);
        chk("lsb_ack_D", 32'(d), 32'b1011);

        // back-to-back frames without ack -> overrun
        sb.push_back('{d: 4'b1100, ov: 1'b0, fe: 1'b0});
        sb.push_back('{d: 4'b0011, ov: 1'b1, fe: 1'b0});
        frame(1'b1, 4'b1100, 1'b0);
        frame(1'b1, 4'b0011, 1'b0);
        idle();
        chk("b2b_D", 32'(d), 32'b0011);
        chk("b2b_valid", 32'(valid), 32'd1);
        chk("b2b_overrun", 32'(overrun), 32'd1);

        // clear after the second bit of a frame
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        sstart = 1'b0;
        clear  = 1'b1;
        #1;
        chk("clr_D", 32'(d), 32'd0);
        chk("clr_valid", 32'(valid), 32'd0);
        chk("clr_busy", 32'(busy), 32'd0);
        chk("clr_overrun", 32'(overrun), 32'd0);
        chk("clr_ferr", 32'(ferr), 32'd0);
        @(negedge clk);
        clear = 1'b0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b1, 1'b1, 1'b0);
            #1 chk("post_clr_valid", 32'(valid), 32'd0);
        end

        // completion with valid=1 and rd_ack on the same edge
        sb.push_back('{d: 4'b1110, ov: 1'b0, fe: 1'b0});
        sb.push_back('{d: 4'b0101, ov: 1'b0, fe: 1'b0});
        frame(1'b1, 4'b1110, 1'b0);
        frame(1'b1, 4'b0101, 1'b1);
        idle();
        chk("ackcomp_valid", 32'(valid), 32'd1);
        chk("ackcomp_overrun", 32'(overrun), 32'd0);
        chk("ackcomp_D", 32'(d), 32'b0101);
        drive(1'b0, 1'b0, 1'b0, 1'b1);
        idle();

        // early sstart on the third bit, restart frame 1001
        sb.push_back('{d: 4'b1001, ov: 1'b0, fe: 1'b1});
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        drive(1'b0, 1'b0, 1'b1, 1'b0);
        #1 chk("restart_busy", 32'(busy), 32'd1);
        drive(1'b0, 1'b1, 1'b1, 1'b0);
        idle();
        chk("restart_ferr", 32'(ferr), 32'd1);
        chk("restart_D", 32'(d), 32'b1001);

        idle();
        idle();
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL missing_words: got %0d pending expected 0",
                     sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/serial_word_receiver.md
SERIAL_WORD_RECEIVER -- requirements
Module: serial_word_receiver

Interface
REQ-001 Parameter WIDTH, default 4, word length in bits; legal range 2..16.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 clear  input  1  reset, asynchronous and active-high.
REQ-004 sin  input  1  serial data bit, sampled every rising edge while receiving.
REQ-005 sstart  input  1  frame start; marks the cycle carrying the first bit of a frame.
REQ-006 msb_first  input  1  bit order; 1 = first bit is MSB, 0 = first bit is LSB; sampled with sstart, held for the frame.
REQ-007 rd_ack  input  1  consumer acknowledge of the word on D.
REQ-008 D  output  WIDTH  last completed word.
REQ-009 valid  output  1  D holds an unacknowledged word.
REQ-010 busy  output  1  frame in progress.
REQ-011 overrun  output  1  sticky; an unacknowledged word was overwritten.
REQ-012 ferr  output  1  sticky; a frame was aborted by an early sstart.

Function
REQ-013 FSM SHALL have two states: IDLE and SHIFT; busy = (state == SHIFT).
REQ-014 IDLE, sstart=0: no change to shift register or bit counter.
REQ-015 IDLE, sstart=1: capture sin as bit 1 of frame, latch msb_first, cnt=1, go to SHIFT.
REQ-016 SHIFT: capture sin each edge, cnt++; the edge capturing bit WIDTH copies the assembled word to D and returns to IDLE.
REQ-017 msb_first=1 assembly: sr = {sr[WIDTH-2:0], sin}; first bit ends in D[WIDTH-1].
REQ-018 msb_first=0 assembly: sr = {sin, sr[WIDTH-1:1]}; first bit ends in D[0].
REQ-019 Latency: sstart at edge k, word on D and valid=1 after edge k+WIDTH-1.
REQ-020 D SHALL change only on frame completion; it holds its value otherwise.
REQ-021 Back-to-back frames SHALL be supported: sstart on the first edge after completion starts the next frame, with zero gap.
REQ-022 sstart=1 in SHIFT, including on the final-bit edge: discard the partial word, set ferr, restart the frame with the current sin as bit 1, cnt=1.
REQ-023 valid SHALL set on completion and clear on the edge where rd_ack=1 and no completion occurs.
REQ-024 Completion with valid=1 and rd_ack=0: D is overwritten, valid stays 1, and overrun is set.
REQ-025 Completion with valid=1 and rd_ack=1 on the same edge: D is updated, valid stays 1, overrun is unchanged.
REQ-026 rd_ack with valid=0 SHALL have no effect.
REQ-027 overrun and ferr SHALL clear only on reset.

Reset
REQ-028 clear=1 SHALL immediately, without a clock edge, force state=IDLE, cnt=0, sr=0, D=0, valid=0, busy=0, overrun=0, ferr=0.
REQ-029 clear asserted mid-frame SHALL discard the partial frame; no completion follows its release.
REQ-030 After clear falls, the first sstart SHALL start a clean frame.

Verification (WIDTH=4, 10 ns clock)
REQ-031 Frame with msb_first=1, sin=1,0,1,1 on four edges (sstart on the first) -> D=1011, valid=1 after the 4th edge, busy=1 on edges 1-3.
REQ-032 Frame with msb_first=0, sin=1,1,0,1 -> D=1011, valid=1; rd_ack pulse -> valid=0, D stays 1011.
REQ-033 Frames 1100 then 0011, back-to-back (msb_first=1), no rd_ack -> D=0011, valid=1, overrun=1.
REQ-034 Completion of 0101 with valid=1 and rd_ack=1 on the same edge -> D=0101, valid=1, overrun=0.
REQ-035 sstart re-asserted on the 3rd bit of a frame, then bits 1,0,0,1 (msb_first=1) -> ferr=1, D=1001 four edges after the re-start.
REQ-036 clear pulsed after the 2nd bit of a frame -> all outputs 0 asynchronously; no valid in the following 4 cycles without sstart.
